// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared constants for the instruction-memory loader.
// Holds FSM state codes, memory depth, address width and bytes per word.
package imem_loader_pkg;

  localparam int WORD_W         = 32;
  localparam int IMEM_DEPTH     = 64;
  localparam int ADDR_W         = 6;
  localparam int BYTES_PER_WORD = 4;

  localparam logic [1:0] S_LEN  = 2'd0;
  localparam logic [1:0] S_DATA = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam logic [1:0] S_ERR  = 2'd3;

endpackage

// File: rtl/imem_loader_if.sv
// imem_loader_if: host byte stream in, instruction RAM write and status out.
// master = host/RAM side, slave = loader side.
interface imem_loader_if;
  import imem_loader_pkg::*;

  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [WORD_W-1:0] wdata;
  logic              cpu_hold;
  logic              done;
  logic              error;

  modport master (
    output rx_data, rx_valid,
    input  rx_ready, we, waddr, wdata,
    input  cpu_hold, done, error
  );

  modport slave (
    input  rx_data, rx_valid,
    output rx_ready, we, waddr, wdata,
    output cpu_hold, done, error
  );

endinterface

// File: rtl/imem_loader_word_packer.sv
// word_packer: packs accepted bytes little-endian into a 32-bit word.
// Ports: clk, reset, byte_v_i/byte_i in; word_v_o pulse with word_o out.
module word_packer
  import imem_loader_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              byte_v_i,
  input  logic [7:0]        byte_i,
  output logic              word_v_o,
  output logic [WORD_W-1:0] word_o
);

  logic [23:0] sh_q, sh_d;
  logic [1:0]  idx_q, idx_d;

  // Bytes enter at the top so byte 0 ends in the low lane.
  always_comb begin
    sh_d  = sh_q;
    idx_d = idx_q;
    if (byte_v_i) begin
      sh_d  = {byte_i, sh_q[23:8]};
      idx_d = idx_q + 2'd1;
    end
  end

  assign word_v_o = byte_v_i && (idx_q == 2'(BYTES_PER_WORD - 1));
  assign word_o   = {byte_i, sh_q};

  always_ff @(posedge clk) begin
    if (!reset) begin
      sh_q  <= '0;
      idx_q <= '0;
    end else begin
      sh_q  <= sh_d;
      idx_q <= idx_d;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// imem_loader: length-prefixed byte-stream loader for the instruction RAM.
// Ports: clk, reset (sync, active low), bus (slave modport of imem_loader_if).
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int N     = WORD_W,
  parameter int DEPTH = IMEM_DEPTH
) (
  input  logic         clk,
  input  logic         reset,
  imem_loader_if.slave bus
);

  logic [1:0]        st_q, st_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] lm1_q, lm1_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [N-1:0]      wdata_q, wdata_d;
  logic              last_q, last_d;
  logic              we_q, we_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              hold_q, hold_d;
  logic              in_len, in_data, rdy, acc;
  logic              word_v;
  logic [N-1:0]      word;

  assign in_len  = (st_q == S_LEN);
  assign in_data = (st_q == S_DATA);
  assign rdy     = in_len | in_data;
  assign acc     = bus.rx_valid & rdy;

  word_packer u_pack (
    .clk      (clk),
    .reset    (reset),
    .byte_v_i (acc & in_data & ~last_q),
    .byte_i   (bus.rx_data),
    .word_v_o (word_v),
    .word_o   (word)
  );

  always_comb begin
    st_d    = st_q;
    cnt_d   = cnt_q;
    lm1_d   = lm1_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    last_d  = last_q;
    we_d    = 1'b0;
    done_d  = done_q;
    err_d   = err_q;
    hold_d  = hold_q;
    unique case (1'b1)
      in_len: begin
        if (acc) begin
          if (bus.rx_data == 8'd0) begin
            st_d   = S_DONE;
            done_d = 1'b1;
            hold_d = 1'b0;
          end else if (int'(bus.rx_data) > DEPTH) begin
            st_d  = S_ERR;
            err_d = 1'b1;
          end else begin
            st_d  = S_DATA;
            cnt_d = '0;
            // Store L-1 so L=DEPTH fits the address width.
            lm1_d = ADDR_W'(bus.rx_data - 8'd1);
          end
        end
      end
      in_data: begin
        // Final write went out last cycle; finish now.
        if (last_q) begin
          st_d   = S_DONE;
          done_d = 1'b1;
          hold_d = 1'b0;
        end else if (word_v) begin
          we_d    = 1'b1;
          waddr_d = cnt_q;
          wdata_d = word;
          if (cnt_q == lm1_q) last_d = 1'b1;
          else cnt_d = cnt_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      st_q    <= S_LEN;
      cnt_q   <= '0;
      lm1_q   <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
      last_q  <= 1'b0;
      we_q    <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      hold_q  <= 1'b1;
    end else begin
      st_q    <= st_d;
      cnt_q   <= cnt_d;
      lm1_q   <= lm1_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      last_q  <= last_d;
      we_q    <= we_d;
      done_q  <= done_d;
      err_q   <= err_d;
      hold_q  <= hold_d;
    end
  end

  assign bus.rx_ready = rdy;
  assign bus.we       = we_q;
  assign bus.waddr    = waddr_q;
  assign bus.wdata    = wdata_q;
  assign bus.cpu_hold = hold_q;
  assign bus.done     = done_q;
  assign bus.error    = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed bench for imem_loader.
// Logs RAM writes and checks them against hand-built expected images.
module tb_imem_loader;

  logic clk;
  logic reset;
  int   n_assert;
  int   n_fail;

  logic [5:0]  wa_log[$];
  logic [31:0] wd_log[$];
  logic [7:0]  img[256];

  imem_loader_if bus();

  imem_loader #(.N(32), .DEPTH(64)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.we === 1'b1) begin
      wa_log.push_back(bus.waddr);
      wd_log.push_back(bus.wdata);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.rx_valid = 1'b0;
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  task automatic idle(input int k);
    bus.rx_valid = 1'b0;
    repeat (k) tick();
  endtask

  task automatic send(input logic [7:0] b);
    int n;
    n = 0;
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    while (bus.rx_ready !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) chk("send_timeout", 32'(n), 32'd0);
    tick();
    bus.rx_valid = 1'b0;
  endtask

  task automatic clear_log();
    wa_log.delete();
    wd_log.delete();
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    reset    = 1'b1;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    tick();

    // Reset values
    do_reset();
    chk("rst_ready", 32'(bus.rx_ready), 32'd1);
    chk("rst_we",    32'(bus.we),       32'd0);
    chk("rst_waddr", 32'(bus.waddr),    32'd0);
    chk("rst_wdata", bus.wdata,         32'd0);
    chk("rst_hold",  32'(bus.cpu_hold), 32'd1);
    chk("rst_done",  32'(bus.done),     32'd0);
    chk("rst_err",   32'(bus.error),    32'd0);
    clear_log();

    // One-word image, back-to-back bytes
    send(8'h01);
    send(8'h17);
    send(8'h00);
    send(8'h00);
    send(8'hB5);
    chk("w1_we",    32'(bus.we),       32'd1);
    chk("w1_waddr", 32'(bus.waddr),    32'd0);
    chk("w1_wdata", bus.wdata,         32'hB5000017);
    chk("w1_done0", 32'(bus.done),     32'd0);
    chk("w1_hold0", 32'(bus.cpu_hold), 32'd1);
    tick();
    chk("w1_done",  32'(bus.done),     32'd1);
    chk("w1_hold",  32'(bus.cpu_hold), 32'd0);
    chk("w1_we0",   32'(bus.we),       32'd0);
    chk("w1_rdy",   32'(bus.rx_ready), 32'd0);

    // Extra bytes after done are ignored
    bus.rx_data  = 8'hAA;
    bus.rx_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("xtra_rdy",  32'(bus.rx_ready), 32'd0);
      chk("xtra_done", 32'(bus.done),     32'd1);
    end
    bus.rx_valid = 1'b0;
    chk("w1_nwr", 32'(wa_log.size()), 32'd1);

    // Zero length
    do_reset();
    clear_log();
    send(8'h00);
    chk("z_done", 32'(bus.done),     32'd1);
    chk("z_hold", 32'(bus.cpu_hold), 32'd0);
    chk("z_rdy",  32'(bus.rx_ready), 32'd0);
    chk("z_we",   32'(bus.we),       32'd0);
    idle(3);
    chk("z_nwr",  32'(wa_log.size()), 32'd0);

    // Oversize length 65
    do_reset();
    clear_log();
    send(8'h41);
    chk("e_err",  32'(bus.error),    32'd1);
    chk("e_hold", 32'(bus.cpu_hold), 32'd1);
    chk("e_rdy",  32'(bus.rx_ready), 32'd0);
    chk("e_done", 32'(bus.done),     32'd0);
    bus.rx_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.rx_data = 8'(i + 1);
      tick();
      chk("e_rdy_k", 32'(bus.rx_ready), 32'd0);
    end
    bus.rx_valid = 1'b0;
    chk("e_err_k", 32'(bus.error),    32'd1);
    chk("e_nwr",   32'(wa_log.size()), 32'd0);

    // Full 64-word image with random gaps
    do_reset();
    clear_log();
    for (int i = 0; i < 256; i++) img[i] = 8'($urandom);
    send(8'h40);
    for (int i = 0; i < 256; i++) begin
      if (i >= 16) idle($urandom_range(0, 2));
      send(img[i]);
    end
    idle(3);
    chk("f_done", 32'(bus.done),      32'd1);
    chk("f_hold", 32'(bus.cpu_hold),  32'd0);
    chk("f_nwr",  32'(wa_log.size()), 32'd64);
    for (int w = 0; w < 64; w++) begin
      if (w < wa_log.size()) begin
        chk("f_addr", 32'(wa_log[w]), 32'(w));
        chk("f_data", wd_log[w],
            {img[4*w+3], img[4*w+2], img[4*w+1], img[4*w]});
      end
    end

    // Reset mid-load, then fresh image
    do_reset();
    clear_log();
    send(8'h02);
    for (int i = 0; i < 6; i++) send(8'(8'h11 + i));
    idle(1);
    chk("r_nwr1", 32'(wa_log.size()), 32'd1);
    if (wd_log.size() > 0) chk("r_w0", wd_log[0], 32'h14131211);
    do_reset();
    chk("r_we0",   32'(bus.we),    32'd0);
    chk("r_waddr", 32'(bus.waddr), 32'd0);
    chk("r_done0", 32'(bus.done),  32'd0);
    clear_log();
    send(8'h01);
    send(8'hEF);
    send(8'hBE);
    send(8'hAD);
    send(8'hDE);
    idle(3);
    chk("r_nwr", 32'(wa_log.size()), 32'd1);
    if (wa_log.size() > 0) begin
      chk("r_addr", 32'(wa_log[0]), 32'd0);
      chk("r_data", wd_log[0],      32'hDEADBEEF);
    end
    chk("r_done", 32'(bus.done), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter N, default 32, instruction word width in bits; the block SHALL support only N=32.
REQ-002 Parameter DEPTH, default 64, number of instruction memory words; the block SHALL derive address width as log2(DEPTH)=6.
REQ-003 clk  input  1  single clock; all state SHALL change on the rising edge only.
REQ-004 reset  input  1  synchronous, active-low reset; it SHALL be sampled on the rising edge of clk.
REQ-005 rx_data  input  8  byte from the host byte stream.
REQ-006 rx_valid  input  1  rx_data holds a valid byte.
REQ-007 rx_ready  output  1  loader accepts a byte this cycle.
REQ-008 we  output  1  one-cycle write strobe to the instruction RAM.
REQ-009 waddr  output  6  instruction RAM word address.
REQ-010 wdata  output  N  instruction word to write.
REQ-011 cpu_hold  output  1  keeps the processor in reset while the image loads.
REQ-012 done  output  1  image fully written, sticky until reset.
REQ-013 error  output  1  illegal length byte received, sticky until reset.

Function
REQ-014 A byte SHALL be accepted only in a cycle where rx_valid=1 and rx_ready=1; the host SHALL hold rx_data stable while rx_valid=1 and rx_ready=0.
REQ-015 States: LEN, DATA, DONE, ERR; the state after reset SHALL be LEN.
REQ-016 rx_ready SHALL be 1 in LEN and DATA and 0 in DONE and ERR.
REQ-017 In LEN, the first accepted byte is word count L. L=0 -> DONE. 1<=L<=DEPTH -> DATA with word index 0 and byte index 0. L>DEPTH -> ERR.
REQ-018 In DATA, bytes SHALL be packed little-endian: byte k of a word (k=0..3) goes to bits [8k+7:8k].
REQ-019 On acceptance of byte 3 at cycle t, we SHALL be 1 at cycle t+1 only, with waddr = word index and wdata = the assembled word.
REQ-020 Word index SHALL increment by 1 after each write; byte index SHALL wrap 3->0.
REQ-021 When the write of word L-1 is issued (cycle t+1), state SHALL be DONE from cycle t+2. From that cycle done=1 and cpu_hold=0.
REQ-022 In LEN and DATA, cpu_hold SHALL be 1. In ERR, cpu_hold SHALL be 1 and error SHALL be 1.
REQ-023 DONE and ERR SHALL be absorbing; only reset leaves them. Bytes offered in these states SHALL be ignored and not consumed.
REQ-024 When rx_valid is low, the loader SHALL stall without timeout. Partial word contents and indices SHALL be retained.
REQ-025 waddr SHALL never exceed DEPTH-1. With L=DEPTH, the final write SHALL be to address 63 with no wrap.
REQ-026 A byte accepted in the same cycle as a we pulse SHALL be packed normally; back-to-back accepts SHALL sustain 1 byte per cycle.

Reset
REQ-027 While reset=0 at a clock edge, the next cycle SHALL have: state LEN, rx_ready=1, we=0, waddr=0, wdata=0, cpu_hold=1, done=0, error=0, indices=0.
REQ-028 Reset asserted mid-load SHALL discard partial words. No we pulse SHALL be issued in the cycle following reset. The next load SHALL restart at address 0.

Structure
REQ-029 Package imem_loader_pkg SHALL hold the state enum, DEPTH, the address-width constant and the byte-count constant 4.
REQ-030 One sub-module word_packer SHALL hold the byte shift/pack register and the byte index, and SHALL emit a word-complete pulse. The FSM, word counter and output registers SHALL reside in imem_loader.
REQ-031 All outputs SHALL be registered, except rx_ready, which SHALL be decoded from state only.

Verification
REQ-032 Bytes 01,17,00,00,B5 at one per cycle -> single we with waddr=0, wdata=32'hB5000017. done=1 and cpu_hold=0 two cycles after the last byte.
REQ-033 Length 00 -> no we pulse; done=1 in the cycle after acceptance; rx_ready=0 thereafter.
REQ-034 Length 41 (65) -> error=1, cpu_hold=1, rx_ready=0; subsequent bytes are never accepted and produce no we.
REQ-035 Length 40 (64) followed by 256 bytes with random rx_valid gaps -> exactly 64 we pulses at addresses 0..63 in order, with data matching a model; done=1 afterwards.
REQ-036 Length 02, six data bytes, then reset=0 for one cycle, then a fresh image 01,EF,BE,AD,DE -> no write of the partial word; one write with waddr=0, wdata=32'hDEADBEEF.
REQ-037 Extra bytes offered after done=1 -> rx_ready stays 0, no we, and done stays 1.
